// File: rtl/pool2d_pkg.sv
// pool2d_pkg: register map, FSM encoding and lane-count helper shared by the pool2d_stream files.
package pool2d_pkg;
    typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_e;
    localparam logic [7:0] A_CTRL   = 8'h00;
    localparam logic [7:0] A_STATUS = 8'h04;
    localparam logic [7:0] A_FLEN   = 8'h08;
    localparam logic [7:0] A_NGRP   = 8'h0C;
    localparam logic [7:0] A_MODE   = 8'h10;
    localparam logic [7:0] A_CNT    = 8'h14;
    function automatic int lanes_of(input int data_w, input int lane_w);
        return data_w / lane_w;
    endfunction
endpackage

// File: rtl/pool2d_lane_op.sv
// pool2d_lane_op: signed max (or sum when POOL2D_AVG_EN is defined) of two elements, one bit wider out.
module pool2d_lane_op
    import pool2d_pkg::*;
#(
    parameter int W = 8
) (
    input  logic signed [W-1:0] a,
    input  logic signed [W-1:0] b,
    input  logic                mode,
    output logic signed [W:0]   y
);
    logic signed [W:0] mx;
    assign mx = (a > b) ? {a[W-1], a} : {b[W-1], b};
`ifdef POOL2D_AVG_EN
    assign y = mode ? {a[W-1], a} + {b[W-1], b} : mx;
`else
    logic unused_mode;
    assign unused_mode = mode;
    assign y = mx;
`endif
endmodule

// File: rtl/pool2d_stream.sv
// pool2d_stream: APB-configured 2x2 stride-2 max pooling over an AXI-Stream pixel stream;
// average pooling is built only when POOL2D_AVG_EN is defined.
module pool2d_stream
    import pool2d_pkg::*;
#(
    parameter int DATA_W   = 32,
    parameter int LANE_W   = 8,
    parameter int MAX_FLEN = 64
) (
    input  logic                CLK,
    input  logic                RESET,
    input  logic [DATA_W-1:0]   S_AXIS_TDATA,
    input  logic                S_AXIS_TVALID,
    input  logic                S_AXIS_TLAST,
    input  logic                S_AXIS_TUSER,
    input  logic [DATA_W/8-1:0] S_AXIS_TKEEP,
    output logic                S_AXIS_TREADY,
    output logic [DATA_W-1:0]   M_AXIS_TDATA,
    output logic                M_AXIS_TVALID,
    output logic                M_AXIS_TLAST,
    output logic                M_AXIS_TUSER,
    output logic [DATA_W/8-1:0] M_AXIS_TKEEP,
    input  logic                M_AXIS_TREADY,
    input  logic [31:0]         PADDR,
    input  logic                PSEL,
    input  logic                PENABLE,
    input  logic                PWRITE,
    input  logic [31:0]         PWDATA,
    output logic [31:0]         PRDATA,
    output logic                PREADY,
    output logic                PSLVERR
);
    localparam int LANES = lanes_of(DATA_W, LANE_W);
    localparam int AW = $clog2(MAX_FLEN / 2);
`ifdef POOL2D_AVG_EN
    localparam int PW = LANE_W + 1;  // pair sums keep their carry so the 4-way average floors exactly
`else
    localparam int PW = LANE_W;
`endif
    localparam int LB_W = LANES * PW;

    state_e              state_q, state_d;
    logic [6:0]          flen_q, flen_d, row_q, row_d, col_q, col_d;
    logic [8:0]          ngrp_q, ngrp_d, grp_q, grp_d;
    logic                mode_q, mode_d, done_q, done_d, in_done_q, in_done_d;
    logic                ovld_q, ovld_d, olast_q, olast_d;
    logic [31:0]         cnt_q, cnt_d;
    logic [DATA_W-1:0]   hold_q, hold_d, out_q, out_d, fin;
    logic [LB_W-1:0]     lb_mem [MAX_FLEN/2];
    logic [LB_W-1:0]     lb_rd_q, pair;
    logic [AW-1:0]       lb_addr;
    logic [7:0]          a;
    logic [31:0]         prdata;
    logic                wr, busy, flen_bad, cfg_wr, err, start, acc;
    logic                col_end, row_end, grp_end, lb_we, win, unused_ok;

    assign a        = PADDR[7:0];
    assign wr       = PSEL & PENABLE & PWRITE;
    assign busy     = state_q == S_RUN;
    assign flen_bad = PWDATA[0] | (PWDATA == 32'd0) | (PWDATA > MAX_FLEN);
    assign cfg_wr   = wr & (a == A_FLEN | a == A_NGRP | a == A_MODE);
    assign err      = cfg_wr & (busy | (a == A_FLEN & flen_bad) | (a == A_NGRP & PWDATA[8:0] == 9'd0));
    assign start    = wr & (a == A_CTRL) & PWDATA[0] & !busy;
    assign acc      = S_AXIS_TVALID & S_AXIS_TREADY;
    assign col_end  = col_q == flen_q - 7'd1;
    assign row_end  = row_q == flen_q - 7'd1;
    assign grp_end  = grp_q == ngrp_q - 9'd1;
    assign lb_addr  = col_q[AW:1];
    assign lb_we    = acc & !row_q[0] & col_q[0];
    assign win      = acc & row_q[0] & col_q[0];

    assign S_AXIS_TREADY = busy & (!ovld_q | M_AXIS_TREADY) & !in_done_q;
    assign M_AXIS_TDATA  = out_q;
    assign M_AXIS_TVALID = ovld_q;
    assign M_AXIS_TLAST  = olast_q;
    assign M_AXIS_TUSER  = 1'b0;
    assign M_AXIS_TKEEP  = '1;
    assign PREADY        = 1'b1;
    assign PSLVERR       = err & !RESET;
    assign prdata = a == A_STATUS ? {30'd0, busy, done_q} :
                    a == A_FLEN   ? {25'd0, flen_q} :
                    a == A_NGRP   ? {23'd0, ngrp_q} :
                    a == A_MODE   ? {31'd0, mode_q} :
                    a == A_CNT    ? cnt_q : 32'd0;
    assign PRDATA    = (PSEL & !RESET) ? prdata : 32'd0;
    assign unused_ok = ^{PADDR[31:8], S_AXIS_TLAST, S_AXIS_TUSER, S_AXIS_TKEEP};

    for (genvar i = 0; i < LANES; i++) begin : g_lane
        logic signed [LANE_W-1:0] px, hd;
        logic signed [LANE_W:0]   p, lbx;
        logic signed [LANE_W+1:0] q;
        assign px = S_AXIS_TDATA[i*LANE_W +: LANE_W];
        assign hd = hold_q[i*LANE_W +: LANE_W];
        assign pair[i*PW +: PW] = p[PW-1:0];
        pool2d_lane_op #(.W(LANE_W)) u_pair (.a(hd), .b(px), .mode(mode_q), .y(p));
        pool2d_lane_op #(.W(LANE_W + 1)) u_win (.a(lbx), .b(p), .mode(mode_q), .y(q));
`ifdef POOL2D_AVG_EN
        assign lbx = lb_rd_q[i*PW +: PW];
        assign fin[i*LANE_W +: LANE_W] = mode_q ? q[LANE_W+1:2] : q[LANE_W-1:0];
`else
        logic unused_q;
        assign lbx = {lb_rd_q[i*PW+PW-1], lb_rd_q[i*PW +: PW]};
        assign fin[i*LANE_W +: LANE_W] = q[LANE_W-1:0];
        assign unused_q = ^q[LANE_W+1:LANE_W];
`endif
    end

    // The read address only changes on accepted beats, so the entry is ready by the odd column.
    always_ff @(posedge CLK) begin
        if (lb_we) lb_mem[lb_addr] <= pair;
        lb_rd_q <= lb_mem[lb_addr];
    end

    always_comb begin
        state_d = state_q;
        flen_d = flen_q;
        ngrp_d = ngrp_q;
        mode_d = mode_q;
        done_d = done_q;
        cnt_d = cnt_q;
        row_d = row_q;
        col_d = col_q;
        grp_d = grp_q;
        in_done_d = in_done_q;
        hold_d = hold_q;
        out_d = out_q;
        ovld_d = ovld_q;
        olast_d = olast_q;
        if (wr && !err) begin
            if (a == A_FLEN) flen_d = PWDATA[6:0];
            if (a == A_NGRP) ngrp_d = PWDATA[8:0];
`ifdef POOL2D_AVG_EN
            if (a == A_MODE) mode_d = PWDATA[0];
`endif
        end
        if (busy) cnt_d = cnt_q + 32'd1;
        if (ovld_q && M_AXIS_TREADY) begin
            ovld_d = 1'b0;
            if (olast_q) begin
                state_d = S_DONE;
                done_d = 1'b1;
            end
        end
        if (acc) begin
            if (!col_q[0]) hold_d = S_AXIS_TDATA;
            col_d = col_end ? 7'd0 : col_q + 7'd1;
            if (col_end) begin
                row_d = row_end ? 7'd0 : row_q + 7'd1;
                if (row_end) begin
                    grp_d = grp_end ? 9'd0 : grp_q + 9'd1;
                    in_done_d = grp_end;
                end
            end
            if (win) begin
                out_d = fin;
                ovld_d = 1'b1;
                olast_d = row_end & col_end & grp_end;
            end
        end
        if (start) begin
            state_d = S_RUN;
            done_d = 1'b0;
            cnt_d = 32'd0;
            row_d = 7'd0;
            col_d = 7'd0;
            grp_d = 9'd0;
            in_done_d = 1'b0;
            ovld_d = 1'b0;
            olast_d = 1'b0;
        end
    end

    always_ff @(posedge CLK) begin
        if (RESET) begin
            state_q <= S_IDLE;
            flen_q <= '0;
            ngrp_q <= '0;
            mode_q <= 1'b0;
            done_q <= 1'b0;
            cnt_q <= '0;
            row_q <= '0;
            col_q <= '0;
            grp_q <= '0;
            in_done_q <= 1'b0;
            hold_q <= '0;
            out_q <= '0;
            ovld_q <= 1'b0;
            olast_q <= 1'b0;
        end else begin
            state_q <= state_d;
            flen_q <= flen_d;
            ngrp_q <= ngrp_d;
            mode_q <= mode_d;
            done_q <= done_d;
            cnt_q <= cnt_d;
            row_q <= row_d;
            col_q <= col_d;
            grp_q <= grp_d;
            in_done_q <= in_done_d;
            hold_q <= hold_d;
            out_q <= out_d;
            ovld_q <= ovld_d;
            olast_q <= olast_d;
        end
    end
endmodule

// File: doc/pool2d_stream.md
POOL2D_STREAM -- requirements
Module: pool2d_stream

Interface
REQ-001 SHALL have parameter DATA_W, default 32, AXIS data width in bits; multiple of LANE_W.
REQ-002 SHALL have parameter LANE_W, default 8, width of one signed channel element; LANES = DATA_W/LANE_W.
REQ-003 SHALL have parameter MAX_FLEN, default 64, largest supported feature-map side; line-buffer depth = MAX_FLEN/2.
REQ-004 SHALL have ports (one clock; reset synchronous, active-high):
  CLK  in  1  sole clock
  RESET  in  1  synchronous active-high reset
  S_AXIS_TDATA/TVALID/TLAST/TUSER/TKEEP  in  DATA_W/1/1/1/DATA_W/8  input pixel stream; TLAST, TUSER, TKEEP ignored
  S_AXIS_TREADY  out  1  input ready
  M_AXIS_TDATA  out  DATA_W  pooled pixel, LANES lanes
  M_AXIS_TVALID/TLAST/TUSER  out  1 each  output valid / last beat / always 0
  M_AXIS_TKEEP  out  DATA_W/8  always all-ones
  M_AXIS_TREADY  in  1  output ready
  PADDR  in  32  APB address; only [7:0] decoded
  PSEL/PENABLE/PWRITE  in  1 each  APB control
  PWDATA  in  32  APB write data
  PRDATA  out  32  APB read data
  PREADY  out  1  constant 1
  PSLVERR  out  1  error on rejected write

Function
REQ-005 SHALL perform 2x2 stride-2 pooling, lane-wise, on NUM_GRP planes of FLEN x FLEN beats; each beat = LANES channels of one pixel; order plane-major, then row, then column.
REQ-006 SHALL decode APB registers: 0x00 CTRL (W, bit0 start pulse), 0x04 STATUS (R, bit0 done, bit1 busy), 0x08 FLEN (RW, [6:0]), 0x0C NUM_GRP (RW, [8:0]), 0x10 MODE (RW, bit0: 0 max, 1 avg), 0x14 CLK_COUNTER (R); unmapped reads return 0.
REQ-007 SHALL complete a write on PSEL&PENABLE&PWRITE; PSLVERR=1 that cycle if FLEN write is odd, 0, or >MAX_FLEN, or NUM_GRP write is 0, or config write while busy; rejected writes leave registers unchanged.
REQ-008 SHALL use FSM IDLE -> RUN on CTRL start write in IDLE; RUN -> DONE when last output beat is accepted; DONE -> RUN on new start; start in RUN ignored.
REQ-009 SHALL clear done on entering RUN, set done on entering DONE; busy = state==RUN.
REQ-010 SHALL drive S_AXIS_TREADY = (state==RUN) & (!out_valid | M_AXIS_TREADY) & !input_complete.
REQ-011 SHALL, on even row, even column, hold the pixel; on even row, odd column, write pair-result into line buffer at col/2.
REQ-012 SHALL, on odd row, even column, hold the pixel; on odd row, odd column, combine with line-buffer entry col/2 and load the output register.
REQ-013 SHALL assert M_AXIS_TVALID the cycle after the bottom-right window pixel is accepted; hold TDATA/TLAST stable until TVALID&TREADY.
REQ-014 SHALL emit (FLEN/2)^2 x NUM_GRP beats; M_AXIS_TLAST=1 only on the final one.
REQ-015 SHALL in max mode take lane-wise signed maximum of the 4 elements.
REQ-016 SHALL in avg mode sum 4 elements in LANE_W+2 bits signed, arithmetic shift right 2 (floor), truncate to LANE_W.
REQ-017 SHALL wrap row/column/plane counters at FLEN-1/FLEN-1/NUM_GRP-1; line buffer reused per plane without clearing.
REQ-018 SHALL count CLK_COUNTER +1 per cycle in RUN, cleared on start, frozen in DONE/IDLE.

Reset
REQ-019 SHALL on RESET=1 force IDLE; all outputs 0 except M_AXIS_TKEEP all-ones and PREADY 1; FLEN=0, NUM_GRP=0, MODE=0, done=0, counters=0; an in-flight frame is discarded.

Configuration
REQ-020 SHALL compile avg mode only when POOL2D_AVG_EN is defined; without it MODE bit0 reads 0, writes of 1 are ignored (no PSLVERR), and no adder logic exists.

Structure
REQ-021 SHALL place register offsets, FSM state encoding and LANES derivation in shared package pool2d_pkg.
REQ-022 SHALL implement per-lane combine as sub-module pool2d_lane_op (two operands, mode, one result), instantiated LANES times.
REQ-023 SHALL infer line buffer as simple dual-port RAM, MAX_FLEN/2 x DATA_W.

Verification
REQ-024 SHALL cover: FLEN=4, NUM_GRP=1, max mode, inputs 0..15 in lane0 -> outputs 5,7,13,15; TLAST on 4th; done=1.
REQ-025 SHALL cover: avg mode (POOL2D_AVG_EN), window lane0 {-1,-2,-3,-4} -> -3; {1,1,1,2} -> 1.
REQ-026 SHALL cover: M_AXIS_TREADY low 10 cycles mid-frame -> S_AXIS_TREADY low, TDATA stable, no lost beats.
REQ-027 SHALL cover: FLEN write 5 -> PSLVERR=1, FLEN readback unchanged; start during RUN -> ignored.
REQ-028 SHALL cover: RESET asserted mid-frame -> IDLE next cycle, STATUS=0, fresh frame FLEN=2 NUM_GRP=2 -> 2 beats, TLAST on 2nd.
